// File: rtl/score_keeper_if.sv
// Frame-update bus between the note-judgement path and the score keeper.
// The judgement side (master) drives the frame strobe and per-lane counts; the score keeper (slave) drives HUD status.
interface score_keeper_if #(
    parameter int LANES    = 4,
    parameter int CNT_W    = 4,
    parameter int SCORE_W  = 16,
    parameter int COMBO_W  = 10,
    parameter int MULT_MAX = 4
);
    localparam int MULT_W = $clog2(MULT_MAX + 1);

    logic                     frame_clk;
    logic                     pause;
    logic [LANES*CNT_W-1:0]   hit;
    logic [LANES*CNT_W-1:0]   miss;
    logic [SCORE_W-1:0]       score;
    logic [COMBO_W-1:0]       combo;
    logic [COMBO_W-1:0]       max_combo;
    logic [MULT_W-1:0]        mult;
    logic                     update;

    modport master (
        output frame_clk, pause, hit, miss,
        input  score, combo, max_combo, mult, update
    );

    modport slave (
        input  frame_clk, pause, hit, miss,
        output score, combo, max_combo, mult, update
    );
endinterface

// File: rtl/score_keeper.sv
// Per-frame score accumulator: captures summed lane counts on a frame_clk rising edge,
// commits score/combo/multiplier on the following clock.
module score_keeper #(
    parameter int LANES      = 4,
    parameter int CNT_W      = 4,
    parameter int SCORE_W    = 16,
    parameter int COMBO_W    = 10,
    parameter int COMBO_STEP = 64,
    parameter int MULT_MAX   = 4,
    parameter int MISS_PEN   = 1
) (
    input logic           Clk,
    input logic           reset,
    score_keeper_if.slave bus
);
    localparam int SUM_W   = CNT_W + $clog2(LANES);
    localparam int MULT_W  = $clog2(MULT_MAX + 1);
    localparam int RAW_W   = SCORE_W + 8;
    localparam int STEP_W  = $clog2(COMBO_STEP + LANES * (2**CNT_W - 1) + 1);
    localparam int CACC_W  = ((COMBO_W > SUM_W) ? COMBO_W : SUM_W) + 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    logic                 frame_clk_delayed;
    logic                 frame_edge;
    logic [SUM_W-1:0]     hit_sum, miss_sum;
    logic [SUM_W-1:0]     hit_q, miss_q;
    logic                 valid_q;

    logic [SCORE_W-1:0]   score_r, score_next;
    logic [COMBO_W-1:0]   combo_r, combo_next;
    logic [COMBO_W-1:0]   max_r, max_next;
    logic [MULT_W-1:0]    mult_r, mult_next;
    logic [STEP_W-1:0]    step_cnt, step_next;
    logic                 update_r;

    logic signed [RAW_W-1:0] raw;
    logic [CACC_W-1:0]       combo_acc;
    logic [STEP_W-1:0]       step_acc;

    assign frame_edge = bus.frame_clk & ~frame_clk_delayed & ~reset & ~bus.pause;

    always_comb begin
        hit_sum  = '0;
        miss_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_sum  = hit_sum  + SUM_W'(bus.hit[i*CNT_W +: CNT_W]);
            miss_sum = miss_sum + SUM_W'(bus.miss[i*CNT_W +: CNT_W]);
        end
    end

    // Scoring always uses the multiplier in force before this frame, even on a miss frame.
    always_comb begin
        raw = RAW_W'(score_r) + RAW_W'(hit_q) * RAW_W'(mult_r)
            - RAW_W'(miss_q) * RAW_W'(MISS_PEN);
        if (raw[RAW_W-1])
            score_next = '0;
        else if (raw[RAW_W-2:0] > (RAW_W-1)'(SCORE_MAX))
            score_next = SCORE_MAX;
        else
            score_next = raw[SCORE_W-1:0];

        combo_acc = CACC_W'(combo_r) + CACC_W'(hit_q);
        step_acc  = STEP_W'(step_cnt) + STEP_W'(hit_q);
        combo_next = combo_r;
        step_next  = step_cnt;
        mult_next  = mult_r;
        if (miss_q != '0) begin
            combo_next = '0;
            step_next  = '0;
            mult_next  = MULT_W'(1);
        end else begin
            combo_next = (combo_acc > CACC_W'(COMBO_MAX)) ? COMBO_MAX : combo_acc[COMBO_W-1:0];
            if (step_acc >= STEP_W'(COMBO_STEP)) begin
                step_next = step_acc - STEP_W'(COMBO_STEP);
                mult_next = (mult_r == MULT_W'(MULT_MAX)) ? mult_r : mult_r + MULT_W'(1);
            end else begin
                step_next = step_acc;
            end
        end
        max_next = (combo_next > max_r) ? combo_next : max_r;
    end

    always_ff @(posedge Clk) begin
        frame_clk_delayed <= bus.frame_clk;
        if (reset) begin
            valid_q  <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            score_r  <= '0;
            combo_r  <= '0;
            max_r    <= '0;
            mult_r   <= MULT_W'(1);
            step_cnt <= '0;
            update_r <= 1'b0;
        end else begin
            valid_q  <= frame_edge;
            update_r <= valid_q;
            if (frame_edge) begin
                hit_q  <= hit_sum;
                miss_q <= miss_sum;
            end
            if (valid_q) begin
                score_r  <= score_next;
                combo_r  <= combo_next;
                max_r    <= max_next;
                mult_r   <= mult_next;
                step_cnt <= step_next;
            end
        end
    end

    assign bus.score     = score_r;
    assign bus.combo     = combo_r;
    assign bus.max_combo = max_r;
    assign bus.mult      = mult_r;
    assign bus.update    = update_r;
endmodule
